// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
// The producer holds tx_data/tx_valid; the transmitter answers with tx_ready.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: idle-high line, one start bit, 8 data bits LSB first,
// optional parity, one or two stop bits; bytes arrive over a valid/ready handshake.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       frame_done
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             ready;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_of(input logic [7:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  assign bus.tx_ready = ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          tx       <= 1'b1;
          if (bus.tx_valid && ready) begin
            shreg   <= bus.tx_data;
            par_bit <= parity_of(bus.tx_data);
            tx      <= 1'b0;
            ready   <= 1'b0;
            state   <= S_START;
          end else begin
            ready <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // tx always mirrors shreg[0]; the next bit is shreg[1] before the shift lands.
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // frame_done is raised one edge early so it is high during the final stop cycle.
        S_STOP: begin
          tx <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              stop_idx <= 1'b0;
              ready    <= 1'b1;
              state    <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_PRE && stop_idx == STOP_LAST) begin
              frame_done <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes parallel bytes onto a single asynchronous line, with a configurable bit period, optional parity and one or two stop bits. It is the stage directly upstream of the UART receiver: its `tx` output drives the receiver's `rx` input in loopback benches and in the integrated top. The transmitter drives the frame format the receiver expects: idle-high, one low start bit, 8 data bits LSB first, optional parity, then high stop bit(s). Bytes are accepted through a valid/ready handshake.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (868 gives 115200 baud at 100 MHz); legal range ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 and 2.
- `clk`  input  1  system clock; the block uses this single clock.
- `reset`  input  1  synchronous, active-high reset.
- `tx_data`  input  8  byte to send; sampled only on handshake.
- `tx_valid`  input  1  upstream has a byte on `tx_data`.
- `tx_ready`  output  1  block can accept a byte this cycle.
- `tx`  output  1  serial line, registered, idle high.
- `frame_done`  output  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP. The bit-period counter (`$clog2(CLKS_PER_BIT)` bits) counts 0..CLKS_PER_BIT-1, and each state change happens when the counter wraps.
- **IDLE:** `tx`=1 and `tx_ready`=1. When `tx_valid && tx_ready` at an edge:
  - latch `tx_data` into a shift register;
  - compute parity (even = XOR of data bits; odd = its inverse);
  - go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** `tx` = shift-register bit 0, and the register shifts right at each bit boundary.
  - A 3-bit index counts bits 0..7.
  - After bit 7, go to PARITY if PARITY≠0, otherwise go to STOP.
- **PARITY:** `tx` = the latched parity bit for one bit period, then go to STOP.
- **STOP:** `tx`=1 for STOP_BITS × CLKS_PER_BIT cycles.
  - `frame_done`=1 on the final cycle of this period.
  - Then go to IDLE.
- `tx_ready` is 0 in every state except IDLE. While `tx_ready`=0, `tx_valid` and `tx_data` are ignored, and changes to `tx_data` mid-frame have no effect.
- Reset values: `tx`=1, `tx_ready`=0, `frame_done`=0, state IDLE, counters 0, shift register 0. `tx_ready` rises on the first edge after `reset` deasserts.
- Reset mid-frame: at the next edge `tx` returns to 1 and the frame is abandoned. There is no `frame_done` pulse, and the partial frame is not resumed.
- Reset takes priority over a handshake in the same cycle, so the byte is not accepted.

## Timing
- The handshake completes at edge T, and the start bit appears on `tx` from T+1.
- Every bit lasts exactly CLKS_PER_BIT cycles; there is no jitter between bits.
- Frame length is (10 + P + (STOP_BITS−1)) × CLKS_PER_BIT cycles, where P=1 if parity is enabled.
- After STOP the FSM spends one cycle in IDLE with `tx_ready`=1. Back-to-back bytes therefore have a minimum period of frame length + 1 cycle, with that extra cycle at `tx`=1.
- `tx_valid` held high continuously gives a byte every frame length + 1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use CLKS_PER_BIT=4 unless stated otherwise.
- **Reset:** hold `reset` for 3 cycles, then release → `tx`=1 throughout, `tx_ready`=0 during reset and 1 from the first edge after release, `frame_done`=0.
- **Single byte, no parity:** send 0x03 → `tx` sequence is 0,1,1,0,0,0,0,0,0,1, each held 4 cycles (40 cycles total). `frame_done` pulses at cycle 40, and `tx_ready` returns at cycle 41.
- **Parity:** send 0x33 with PARITY=2 → parity bit 0; with PARITY=1 → parity bit 1. Frame is 44 cycles.
- **Two stop bits, back-to-back:** STOP_BITS=2, hold `tx_valid` high with 0xA5 then 0x5A → stop level held 8 cycles, then 1 idle cycle, then the next start bit. The second frame decodes to 0x5A.
- **Ignored inputs:** toggle `tx_data` and `tx_valid` mid-frame → no change to the serial bits, and no extra byte accepted.
- **Loopback with reset abort:** drive the receiver's `rx` from `tx`, send 0x03 → receiver reports 0x03. Assert `reset` during bit 4 of a second frame → `tx`=1 on the next edge and no `frame_done` pulse.
